riscv_mem_arbiter: RTL and testbench

Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences one outstanding transaction at a time through a request/accept/response handshake.
- Data accesses have priority, with a starvation guard so fetch always makes progress.
- Produces per-stage acknowledge and stall signals for the pipeline control, and discards fetches cancelled by a branch/jump flush.

---
 rtl/riscv_mem_pkg.sv | 20 ++
 rtl/riscv_mem_starve_ctr.sv | 27 ++
 rtl/riscv_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/riscv_mem_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module riscv_mem_starve_ctr #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic             sat,
  output logic [CNT_W-1:0] cnt
);

  assign sat = (cnt >= CNT_W'(STARVE_MAX));

  // clr wins over inc so an I grant always restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one outstanding transaction at a time, data first with a fetch starvation guard.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              flush_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state,
  output logic [CNT_W-1:0]  dbg_starve
);

  // Handshakes: a request transfers on the edge where mem_valid && mem_ready;
  // mem_valid and the mem_* fields stay frozen until then. The response is a
  // single mem_rvalid cycle, honoured only in ST_RESP. i_req/d_req are levels
  // held until the matching one-cycle ack.

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  logic             kill, kill_nxt;
  logic             eff_i;
  logic             grant_d, grant_i;
  logic             starve_sat, starve_inc, starve_clr;
  logic             rsp_done;
  logic [CNT_W-1:0] starve_cnt;

  assign eff_i    = i_req && !flush_if;
  assign rsp_done = (state == ST_RESP) && mem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      kill  <= kill_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    kill_nxt  = kill;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_req && (!eff_i || !starve_sat)) begin
          grant_d   = 1'b1;
          owner_nxt = OWN_D;
          state_nxt = ST_REQ;
        end else if (eff_i) begin
          grant_i   = 1'b1;
          owner_nxt = OWN_I;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush_if && (owner == OWN_I)) kill_nxt = 1'b1;
        if (mem_ready) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
          kill_nxt  = 1'b0;
        end else if (flush_if && (owner == OWN_I)) begin
          kill_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
        kill_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'h0;
    end else if (grant_d) begin
      mem_valid <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
    end else if (grant_i) begin
      mem_valid <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= i_addr;
      mem_wdata <= '0;
      mem_be    <= BE_FULL;
    end else if ((state == ST_REQ) && mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  // A flush landing on the response cycle still cancels the fetch.
  assign i_ack     = rsp_done && (owner == OWN_I) && !kill && !flush_if && !rst;
  assign d_ack     = rsp_done && (owner == OWN_D) && !rst;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign stall_if  = i_req && !i_ack;
  assign stall_mem = d_req && !d_ack;

  assign starve_inc = grant_d && i_req;
  assign starve_clr = grant_i || (grant_d && !i_req);

  riscv_mem_starve_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat),
    .cnt (starve_cnt)
  );

  assign dbg_state  = state;
  assign dbg_starve = starve_cnt;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-phase reference model.
module tb_riscv_mem_arbiter;
  import riscv_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int CW   = $clog2(SMAX + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req = 1'b0, flush_if = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = 4'h0;
  logic          i_ack, d_ack, stall_if, stall_mem;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_valid, mem_we;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [3:0]    mem_be;
  state_t        dbg_state;
  logic [CW-1:0] dbg_starve;

  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .flush_if(flush_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Backing store shared by the memory responder and the reference model.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  // ---------------- memory responder ----------------
  int ready_mode = 1;  // 0 random, 1 always ready, 2 never ready
  int rv_min = 0, rv_max = 0;
  bit spurious = 1'b0;
  int xfer_cnt = 0;

  initial begin : responder
    bit          outst, s_x, s_rv, s_rst, cwe, swe;
    int          wt;
    logic [31:0] ca, cw, sa, sw, tmp;
    logic [3:0]  cb, sb;
    outst = 1'b0; wt = 0; cwe = 1'b0; ca = '0; cw = '0; cb = '0;
    forever begin
      @(negedge clk);
      s_x = mem_valid && mem_ready; s_rv = mem_rvalid; s_rst = rst;
      sa = mem_addr; sw = mem_wdata; sb = mem_be; swe = mem_we;
      @(posedge clk); #2;
      if (s_rst) begin
        outst = 1'b0;
      end else begin
        if (s_rv && outst) begin
          if (cwe) begin
            tmp = rd(ca);
            for (int b = 0; b < 4; b++) if (cb[b]) tmp[8*b +: 8] = cw[8*b +: 8];
            ref_mem[ca] = tmp;
          end
          outst = 1'b0;
        end
        if (s_x) begin
          outst = 1'b1; wt = $urandom_range(rv_max, rv_min);
          ca = sa; cw = sw; cb = sb; cwe = swe; xfer_cnt++;
        end
      end
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (outst) begin
        if (wt == 0) begin mem_rvalid = 1'b1; mem_rdata = rd(ca); end
        else wt--;
      end else if (spurious && ($urandom_range(7, 0) == 0)) begin
        mem_rvalid = 1'b1;
      end
      case (ready_mode)
        0:       mem_ready = ($urandom_range(9, 0) < 7);
        1:       mem_ready = 1'b1;
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model + per-cycle checks ----------------
  bit          m_busy = 0, m_acc = 0, m_kill = 0, m_wknown = 1;
  int          m_own = 0;  // 0 none, 1 fetch, 2 data
  int          m_starve = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic        m_we = 1'b0;
  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];
  logic [31:0] grant_log[$];
  int          st_before[$], st_after[$];
  bit          last_i_ack = 0, last_d_ack = 0, prev_valid = 0;
  int          prev_starve = 0;

  initial begin : model
    bit     exp_resp, exp_iack, exp_dack, eff_i;
    state_t es;
    forever begin
      @(negedge clk);
      exp_resp = m_busy && m_acc && mem_rvalid;
      exp_iack = exp_resp && (m_own == 1) && !m_kill && !flush_if && !rst;
      exp_dack = exp_resp && (m_own == 2) && !rst;
      es = !m_busy ? ST_IDLE : (!m_acc ? ST_REQ : ST_RESP);
      check("i_ack", i_ack, exp_iack);
      check("d_ack", d_ack, exp_dack);
      check("stall_if", stall_if, i_req && !exp_iack);
      check("stall_mem", stall_mem, d_req && !exp_dack);
      check("mem_valid", mem_valid, m_busy && !m_acc);
      check("state", 32'(dbg_state), 32'(es));
      check("starve", 32'(dbg_starve), m_starve);
      check("mem_addr", mem_addr, m_addr);
      check("mem_we", mem_we, m_we);
      check("mem_be", mem_be, m_be);
      if (m_wknown) check("mem_wdata", mem_wdata, m_wdata);
      if (exp_iack && i_exp_q.size() > 0) check("i_rdata", i_rdata, i_exp_q[0]);
      if (exp_dack && !m_we && d_exp_q.size() > 0) check("d_rdata", d_rdata, d_exp_q[0]);

      if (!prev_valid && mem_valid) begin
        grant_log.push_back(mem_addr);
        st_before.push_back(prev_starve);
        st_after.push_back(int'(dbg_starve));
      end
      prev_valid  = mem_valid;
      prev_starve = int'(dbg_starve);
      last_i_ack  = i_ack;
      last_d_ack  = d_ack;

      // advance the model across the coming rising edge
      if (rst) begin
        m_busy = 0; m_acc = 0; m_kill = 0; m_own = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0; m_wknown = 1;
        i_exp_q.delete(); d_exp_q.delete();
      end else if (!m_busy) begin
        eff_i = i_req && !flush_if;
        if (d_req && (!eff_i || m_starve < SMAX)) begin
          m_busy = 1; m_acc = 0; m_own = 2;
          m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_be = d_be; m_wknown = 1;
          m_starve = i_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
          if (!d_we) d_exp_q.push_back(rd(d_addr));
        end else if (eff_i) begin
          m_busy = 1; m_acc = 0; m_own = 1;
          m_addr = i_addr; m_we = 1'b0; m_be = 4'hF; m_wknown = 0;
          m_starve = 0;
          i_exp_q.push_back(rd(i_addr));
        end
      end else if (!m_acc) begin
        if (flush_if && m_own == 1) m_kill = 1;
        if (mem_ready) m_acc = 1;
      end else if (mem_rvalid) begin
        if (m_own == 1 && i_exp_q.size() > 0) void'(i_exp_q.pop_front());
        if (m_own == 2 && d_exp_q.size() > 0 && !m_we) void'(d_exp_q.pop_front());
        m_busy = 0; m_acc = 0; m_own = 0; m_kill = 0;
      end else if (flush_if && m_own == 1) begin
        m_kill = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // which: 0 i_ack, 1 d_ack, 2 mem_valid, 3 state RESP, 4 state REQ
  task automatic wait_for(input string tag, input int which, input int maxc, output int cyc);
    bit hit;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      case (which)
        0:       hit = i_ack;
        1:       hit = d_ack;
        2:       hit = mem_valid;
        3:       hit = (dbg_state == ST_RESP);
        default: hit = (dbg_state == ST_REQ);
      endcase
    end while (!hit && cyc < maxc);
    check({tag, "_seen"}, hit, 1);
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(1, 0));
    d_addr  = 32'h2000 + 32'(4 * $urandom_range(15, 0));
    d_wdata = $urandom;
    d_be    = 4'($urandom_range(15, 0));
  endtask

  task automatic test_fetch();
    ref_mem[32'h100] = 32'h00500093;
    step(); i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk); check("f_stall_n", stall_if, 1); check("f_valid_n", mem_valid, 0);
    @(negedge clk); check("f_valid_n1", mem_valid, 1); check("f_addr", mem_addr, 32'h100);
    check("f_we", mem_we, 0); check("f_stall_n1", stall_if, 1);
    @(negedge clk); check("f_ack", i_ack, 1); check("f_rdata", i_rdata, 32'h00500093);
    step(); i_req = 1'b0;
  endtask

  task automatic test_priority();
    int cyc;
    step(); i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    @(negedge clk);
    @(negedge clk); check("p_we", mem_we, 1); check("p_wdata", mem_wdata, 32'hDEADBEEF);
    check("p_addr", mem_addr, 32'h2000);
    @(negedge clk); check("p_dack", d_ack, 1); check("p_iack_early", i_ack, 0);
    step(); d_req = 1'b0; d_we = 1'b0;
    wait_for("p_iack", 0, 12, cyc);
    check("p_ilat", cyc, 3);
    check("p_irdata", i_rdata, rd(32'h300));
    step(); i_req = 1'b0;
  endtask

  task automatic test_starve();
    int k, kind[6];
    bit done;
    kind = '{1, 1, 1, 1, 0, 1};
    grant_log.delete(); st_before.delete(); st_after.delete();
    k = 0; done = 0;
    step(); i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004; d_be = 4'h0;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      if (last_i_ack) i_req = 1'b0;
      if (last_d_ack) begin
        if (grant_log.size() >= 6) begin d_req = 1'b0; done = 1; end
        else begin k++; d_addr = 32'h2004 + 32'(4 * (k % 8)); end
      end
    end
    check("s_done", done, 1);
    check("s_count", (grant_log.size() >= 6), 1);
    if (grant_log.size() >= 6) begin
      for (int j = 0; j < 6; j++) check($sformatf("s_kind%0d", j), (grant_log[j] >= 32'h2000), kind[j]);
      check("s_cnt_before_i", st_before[4], SMAX);
      check("s_cnt_after_i", st_after[4], 0);
    end
  endtask

  task automatic test_flush();
    int cyc;
    ref_mem[32'h104] = 32'hBAD0BAD0; ref_mem[32'h200] = 32'h12345678;
    rv_min = 2; rv_max = 2;
    step(); i_req = 1'b1; i_addr = 32'h104;
    wait_for("fl_resp", 3, 10, cyc);
    step(); flush_if = 1'b1;
    step(); flush_if = 1'b0; i_addr = 32'h200;
    wait_for("fl_ack", 0, 20, cyc);
    check("fl_rdata", i_rdata, 32'h12345678);
    step(); i_req = 1'b0; rv_min = 0; rv_max = 0;
  endtask

  task automatic test_stall();
    int cyc, x0;
    ready_mode = 2;
    step(); i_req = 1'b1; i_addr = 32'h500; x0 = xfer_cnt;
    wait_for("st_valid", 2, 6, cyc);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check("st_hold_valid", mem_valid, 1); check("st_hold_addr", mem_addr, 32'h500);
    end
    ready_mode = 1;
    wait_for("st_ack", 0, 10, cyc);
    check("st_xfers", xfer_cnt - x0, 1);
    step(); i_req = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2010;
    wait_for("r_req", 4, 10, cyc);
    step(); rst = 1'b1; d_req = 1'b0;
    @(negedge clk); check("r_noack_d", d_ack, 0); check("r_noack_i", i_ack, 0);
    step(); rst = 1'b0;
    @(negedge clk);
    check("r_state", 32'(dbg_state), 32'(ST_IDLE)); check("r_valid", mem_valid, 0);
    check("r_addr", mem_addr, 0); check("r_we", mem_we, 0); check("r_wdata", mem_wdata, 0);
    check("r_be", mem_be, 0); check("r_starve", dbg_starve, 0); check("r_dack", d_ack, 0);
  endtask

  task automatic random_phase();
    bit prev_flush;
    prev_flush = 0;
    ready_mode = 0; rv_min = 0; rv_max = 3; spurious = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(399, 0) == 0) begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; flush_if = 1'b0; prev_flush = 0;
      end else begin
        if (i_req) begin
          if (last_i_ack) begin i_req = ($urandom_range(3, 0) != 0); i_addr += 4; end
          else if (prev_flush) i_addr = 32'h100 + 32'(4 * $urandom_range(63, 0));
        end else if ($urandom_range(2, 0) == 0) begin
          i_req = 1'b1; i_addr = 32'h100 + 32'(4 * $urandom_range(63, 0));
        end
        if (d_req) begin
          if (last_d_ack) begin
            if ($urandom_range(1, 0) == 1) new_d(); else d_req = 1'b0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          new_d();
        end
        flush_if   = ($urandom_range(11, 0) == 0);
        prev_flush = flush_if;
      end
    end
    step(); rst = 1'b0; i_req = 1'b0; d_req = 1'b0; flush_if = 1'b0;
    spurious = 1'b0; ready_mode = 1; rv_max = 0;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin : main
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", mem_valid, 0); check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0); check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_starve", dbg_starve, 0); check("rst_iack", i_ack, 0);
    test_fetch();    repeat (2) step();
    test_priority(); repeat (2) step();
    test_starve();   repeat (2) step();
    test_flush();    repeat (2) step();
    test_stall();    repeat (2) step();
    test_reset();    repeat (2) step();
    random_phase();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
